// File: rtl/rr_mux_arb.sv
// N-channel to one registered mux with fixed-select or round-robin arbitration.
// Optional capture counter output grant_cnt enabled by macro RR_MUX_ARB_COUNT_EN.
module rr_mux_arb #(
  parameter int WIDTH = 64,
  parameter int N     = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
`ifdef RR_MUX_ARB_COUNT_EN
  ,output logic [15:0]       grant_cnt
`endif
);

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SELW-1:0]    r_out_sel;
  logic [SELW-1:0]    r_ptr;

  logic               w_load;
  logic               w_fire;
  logic [2*N-1:0]     w_dbl;
  logic [2*N-1:0]     w_shifted;
  logic [SELW:0]      w_shamt;
  logic [N-1:0]       w_rot;
  logic               w_rr_valid;
  logic [SELW-1:0]    w_rr_off;
  logic [SELW:0]      w_rr_sum;
  logic [SELW-1:0]    w_rr_idx;
  logic               w_fix_valid;
  logic               w_grant_valid;
  logic [SELW-1:0]    w_grant_idx;
  logic [WIDTH-1:0]   w_grant_data;

  assign w_load = !r_out_valid || out_ready;

  // Rotate requests so bit k is channel (ptr+1+k) mod N; the lowest set bit wins.
  assign w_dbl     = {in_valid, in_valid};
  assign w_shamt   = {1'b0, r_ptr} + (SELW+1)'(1);
  assign w_shifted = w_dbl >> w_shamt;
  assign w_rot     = w_shifted[N-1:0];

  always_comb begin
    w_rr_valid = 1'b0;
    w_rr_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_rr_valid = 1'b1;
        w_rr_off   = SELW'(k);
      end
    end
  end

  // ptr+1+off never exceeds 2N-1, so a single conditional subtract wraps it.
  assign w_rr_sum = w_shamt + {1'b0, w_rr_off};
  assign w_rr_idx = (w_rr_sum >= (SELW+1)'(N)) ? SELW'(w_rr_sum - (SELW+1)'(N))
                                               : SELW'(w_rr_sum);

  always_comb begin
    w_fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && (sel == SELW'(i))) begin
        w_fix_valid = 1'b1;
      end
    end
  end

  assign w_grant_valid = mode ? w_rr_valid : w_fix_valid;
  assign w_grant_idx   = mode ? w_rr_idx   : sel;
  assign w_fire        = w_load && w_grant_valid && !reset;

  always_comb begin
    w_grant_data = '0;
    in_ready     = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_idx == SELW'(i)) begin
        w_grant_data = in_data[i*WIDTH +: WIDTH];
        in_ready[i]  = w_fire;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= SELW'(N - 1);
    end else if (w_load) begin
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_sel   <= w_grant_idx;
        r_ptr       <= w_grant_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

`ifdef RR_MUX_ARB_COUNT_EN
  logic [15:0] r_grant_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_cnt <= '0;
    end else if (w_fire && (r_grant_cnt != 16'hFFFF)) begin
      r_grant_cnt <= r_grant_cnt + 16'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed self-checking bench for rr_mux_arb (WIDTH=64, N=8).
// Define RR_MUX_ARB_COUNT_EN at build time to also exercise grant_cnt.
module tb_rr_mux_arb;
  localparam int WIDTH = 64;
  localparam int N     = 8;
  localparam int SELW  = $clog2(N);

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;
`ifdef RR_MUX_ARB_COUNT_EN
  logic [15:0]        grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_mux_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef RR_MUX_ARB_COUNT_EN
    ,.grant_cnt(grant_cnt)
`endif
  );

  function automatic logic [WIDTH-1:0] chdata(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i * 17 + 1);
  endfunction

  task automatic load_data();
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = chdata(i);
  endtask

  // Advance one edge and let outputs settle before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; sel = '0;
    load_data();
    #1;
    n_tests++;
    if (in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready: got %h expected 00", in_ready); end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || out_sel !== 3'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b d=%h s=%0d expected v=0 d=0 s=0", out_valid, out_data, out_sel);
    end
    step();
    $display("[TB] reset: v=%b d=%h s=%0d", out_valid, out_data, out_sel);
  endtask

  task automatic test_rr_sweep();
    logic [N-1:0] exp_rdy;
    reset = 1'b0; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 8'h01) begin n_fail++; $display("FAIL rr_first_ready: got %h expected 01", in_ready); end
    for (int c = 0; c < 10; c++) begin
      step();
      exp_rdy = 8'(1 << ((c + 1) % 8));
      $display("[TB] rr cycle %0d: v=%b s=%0d d=%h rdy=%h", c, out_valid, out_sel, out_data, in_ready);
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 3'((c % 8)) || out_data !== chdata(c % 8)) begin
        n_fail++; $display("FAIL rr_sweep_%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                           c, out_valid, out_sel, out_data, c % 8, chdata(c % 8));
      end
      n_tests++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready_%0d: got %h expected %h", c, in_ready, exp_rdy); end
    end
    in_valid = 8'h00;
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_fixed_select();
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08;
    in_data[3*WIDTH +: WIDTH] = 64'hDEAD_BEEF;
    #1;
    n_tests++;
    if (in_ready !== 8'h08) begin n_fail++; $display("FAIL fixed_ready: got %h expected 08", in_ready); end
    step();
    $display("[TB] fixed sel=3: v=%b s=%0d d=%h", out_valid, out_sel, out_data);
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 64'hDEAD_BEEF) begin
      n_fail++; $display("FAIL fixed_capture: got v=%b s=%0d d=%h expected v=1 s=3 d=00000000deadbeef", out_valid, out_sel, out_data);
    end
    sel = 3'd5;
    #1;
    n_tests++;
    if (in_ready !== 8'h00) begin n_fail++; $display("FAIL fixed_nogrant_ready: got %h expected 00", in_ready); end
    step();
    $display("[TB] fixed sel=5: v=%b s=%0d d=%h", out_valid, out_sel, out_data);
    n_tests++;
    if (out_valid !== 1'b0 || out_sel !== 3'd3 || out_data !== 64'hDEAD_BEEF) begin
      n_fail++; $display("FAIL fixed_nogrant_hold: got v=%b s=%0d d=%h expected v=0 s=3 d=00000000deadbeef", out_valid, out_sel, out_data);
    end
    load_data();
  endtask

  task automatic test_back_to_back();
    // ptr is 3 from the fixed-select capture, so round-robin starts at channel 4.
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 3'd4 || out_data !== chdata(4)) begin
      n_fail++; $display("FAIL stall_first: got v=%b s=%0d d=%h expected v=1 s=4 d=%h", out_valid, out_sel, out_data, chdata(4));
    end
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (in_ready !== 8'h00) begin n_fail++; $display("FAIL stall_ready_%0d: got %h expected 00", c, in_ready); end
      step();
      $display("[TB] stall %0d: v=%b s=%0d d=%h rdy=%h", c, out_valid, out_sel, out_data, in_ready);
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 3'd4 || out_data !== chdata(4)) begin
        n_fail++; $display("FAIL stall_hold_%0d: got v=%b s=%0d d=%h expected v=1 s=4 d=%h", c, out_valid, out_sel, out_data, chdata(4));
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 8'h20) begin n_fail++; $display("FAIL release_ready: got %h expected 20", in_ready); end
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 3'd5 || out_data !== chdata(5)) begin
      n_fail++; $display("FAIL release_capture: got v=%b s=%0d d=%h expected v=1 s=5 d=%h", out_valid, out_sel, out_data, chdata(5));
    end
  endtask

  task automatic test_wrap();
    mode = 1'b0; sel = 3'd6; in_valid = 8'h40;
    step();
    n_tests++;
    if (out_sel !== 3'd6) begin n_fail++; $display("FAIL wrap_setup: got s=%0d expected 6", out_sel); end
    mode = 1'b1; in_valid = 8'h41;
    #1;
    n_tests++;
    if (in_ready !== 8'h01) begin n_fail++; $display("FAIL wrap_ready: got %h expected 01", in_ready); end
    step();
    $display("[TB] wrap: v=%b s=%0d", out_valid, out_sel);
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== chdata(0)) begin
      n_fail++; $display("FAIL wrap_grant0: got v=%b s=%0d d=%h expected v=1 s=0 d=%h", out_valid, out_sel, out_data, chdata(0));
    end
    step();
    $display("[TB] wrap: v=%b s=%0d", out_valid, out_sel);
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 3'd6 || out_data !== chdata(6)) begin
      n_fail++; $display("FAIL wrap_grant6: got v=%b s=%0d d=%h expected v=1 s=6 d=%h", out_valid, out_sel, out_data, chdata(6));
    end
  endtask

  task automatic test_reset_mid_transfer();
    out_ready = 1'b0; in_valid = 8'hFF; reset = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 8'h00) begin n_fail++; $display("FAIL midreset_ready: got %h expected 00", in_ready); end
    step();
    $display("[TB] mid reset: v=%b s=%0d d=%h", out_valid, out_sel, out_data);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || out_sel !== 3'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got v=%b d=%h s=%0d expected v=0 d=0 s=0", out_valid, out_data, out_sel);
    end
    reset = 1'b0; out_ready = 1'b1; mode = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_sel !== 3'd0) begin
      n_fail++; $display("FAIL midreset_first_rr: got v=%b s=%0d expected v=1 s=0", out_valid, out_sel);
    end
  endtask

`ifdef RR_MUX_ARB_COUNT_EN
  task automatic test_grant_count();
    reset = 1'b1; in_valid = 8'h00; mode = 1'b1; out_ready = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (grant_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_reset: got %h expected 0000", grant_cnt); end
    in_valid = 8'hFF;
    for (int c = 0; c < 5; c++) step();
    in_valid = 8'h00;
    step();
    $display("[TB] count after 5: %0d", grant_cnt);
    n_tests++;
    if (grant_cnt !== 16'd5) begin n_fail++; $display("FAIL cnt_five: got %0d expected 5", grant_cnt); end
    in_valid = 8'hFF;
    for (int c = 0; c < 65529; c++) step();
    in_valid = 8'h00;
    step();
    n_tests++;
    if (grant_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL cnt_fffe: got %h expected fffe", grant_cnt); end
    in_valid = 8'hFF;
    for (int c = 0; c < 3; c++) step();
    in_valid = 8'h00;
    step();
    $display("[TB] count saturated: %h", grant_cnt);
    n_tests++;
    if (grant_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate: got %h expected ffff", grant_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    test_reset();
    test_rr_sweep();
    test_fixed_select();
    test_back_to_back();
    test_wrap();
    test_reset_mid_transfer();
`ifdef RR_MUX_ARB_COUNT_EN
    test_grant_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
